// File: rtl/stopwatch_lap_core_pkg.sv
// Shared definitions for the stopwatch/lap core.
//  - state_e        : controller states
//  - SEC_W/SEC_MAX  : seconds field width and its highest value
//  - lap_entry_w()  : width of one stored lap {min, sec}
//  - clamp_sec()    : limits a seconds preset to SEC_MAX
package stopwatch_lap_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int          SEC_W   = 6;
  localparam logic [5:0]  SEC_MAX = 6'd59;

  function automatic int lap_entry_w(input int min_w);
    return min_w + SEC_W;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Button-pulse / display bundle of the stopwatch core.
//  master : pulse + preset source (front end / testbench), reads display fields
//  slave  : the stopwatch core
//  Pulses: start_pulse, lap_pulse, clear_pulse, recall_pulse (one cycle each)
//  Config: count_down, preset_min, preset_sec
//  Status: min_binary, sec_binary, running, expired, lap_cnt, lap_full,
//          view_valid, view_idx
interface stopwatch_lap_core_if
  import stopwatch_lap_core_pkg::*;
#(
  parameter int MIN_W  = 7,
  parameter int LAP_AW = 2
) ();

  logic              start_pulse;
  logic              lap_pulse;
  logic              clear_pulse;
  logic              recall_pulse;
  logic              count_down;
  logic [MIN_W-1:0]  preset_min;
  logic [SEC_W-1:0]  preset_sec;
  logic [MIN_W-1:0]  min_binary;
  logic [SEC_W-1:0]  sec_binary;
  logic              running;
  logic              expired;
  logic [LAP_AW:0]   lap_cnt;
  logic              lap_full;
  logic              view_valid;
  logic [LAP_AW-1:0] view_idx;

  modport master (
    output start_pulse, lap_pulse, clear_pulse, recall_pulse,
    output count_down, preset_min, preset_sec,
    input  min_binary, sec_binary, running, expired,
    input  lap_cnt, lap_full, view_valid, view_idx
  );

  modport slave (
    input  start_pulse, lap_pulse, clear_pulse, recall_pulse,
    input  count_down, preset_min, preset_sec,
    output min_binary, sec_binary, running, expired,
    output lap_cnt, lap_full, view_valid, view_idx
  );

endinterface

// File: rtl/stopwatch_lap_core_lap_buffer.sv
// Lap memory: LAP_DEPTH entries of ENTRY_W bits, filled in order.
//  clk, rst      : clock, asynchronous active-high reset
//  i_clr         : synchronous clear of entries and count
//  i_wr_en       : append i_wr_data (ignored while full)
//  i_rd_idx      : asynchronous read index -> o_rd_data
//  o_cnt, o_full : number of stored entries, count == LAP_DEPTH
module stopwatch_lap_core_lap_buffer
  import stopwatch_lap_core_pkg::*;
#(
  parameter int ENTRY_W   = 13,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [LAP_AW-1:0]  i_rd_idx,
  output logic [ENTRY_W-1:0] o_rd_data,
  output logic [LAP_AW:0]    o_cnt,
  output logic               o_full
);

  logic [ENTRY_W-1:0] r_mem [LAP_DEPTH];
  logic [LAP_AW:0]    r_cnt;
  logic [LAP_AW-1:0]  w_wr_ptr;

  // Entries are appended in order, so the write pointer is the low bits of the count.
  assign w_wr_ptr  = r_cnt[LAP_AW-1:0];
  assign o_full    = (r_cnt == (LAP_AW + 1)'(LAP_DEPTH));
  assign o_cnt     = r_cnt;
  assign o_rd_data = r_mem[i_rd_idx];

  // Entry storage and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
      r_cnt <= '0;
    end else if (i_wr_en && !o_full) begin
      r_mem[w_wr_ptr] <= i_wr_data;
      r_cnt           <= r_cnt + (LAP_AW + 1)'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: mm:ss up or down counter with 1 s clock-enable
// prescaler, start/pause control, expiry, lap capture and lap recall.
//  clk   : system clock
//  rst_n : asynchronous reset, ACTIVE-HIGH despite the legacy name
//  bus   : stopwatch_lap_core_if.slave (pulses, presets, display/status)
module stopwatch_lap_core
  import stopwatch_lap_core_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int MIN_W     = 7,
  parameter int MAX_MIN   = 99,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  stopwatch_lap_core_if.slave bus
);

  localparam int                ENTRY_W    = lap_entry_w(MIN_W);
  localparam int                PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [MIN_W-1:0]   MAX_MIN_V  = MIN_W'(MAX_MIN);

  state_e             r_state, w_state_nxt;
  logic [MIN_W-1:0]   r_min, w_min_nxt;
  logic [SEC_W-1:0]   r_sec, w_sec_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic               r_view_valid, w_view_valid_nxt;
  logic [LAP_AW-1:0]  r_view_idx, w_view_idx_nxt;

  logic               w_tick, w_at_max, w_tick_expire, w_lap_wr;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic [LAP_AW:0]    w_lap_cnt;
  logic               w_lap_full;

  assign w_tick   = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_at_max = (r_min == MAX_MIN_V) && (r_sec == SEC_MAX);
  // Down: ticks from 00:01 (or a stray 00:00) end the run. Up: MAX_MIN:59 holds.
  assign w_tick_expire = bus.count_down ? ((r_min == '0) && (r_sec <= 6'd1)) : w_at_max;
  // Lap stores the pre-edge time, so a simultaneous tick is not yet included.
  assign w_lap_wr = bus.lap_pulse && (r_state == ST_RUN) && !bus.clear_pulse;

  stopwatch_lap_core_lap_buffer #(
    .ENTRY_W   (ENTRY_W),
    .LAP_DEPTH (LAP_DEPTH),
    .LAP_AW    (LAP_AW)
  ) u_lap_buffer (
    .clk       (clk),
    .rst       (rst_n),
    .i_clr     (bus.clear_pulse),
    .i_wr_en   (w_lap_wr),
    .i_wr_data ({r_min, r_sec}),
    .i_rd_idx  (r_view_idx),
    .o_rd_data (w_rd_entry),
    .o_cnt     (w_lap_cnt),
    .o_full    (w_lap_full)
  );

  // Next-state logic: clear dominates, then FSM/prescaler/time, then recall.
  always_comb begin
    w_state_nxt      = r_state;
    w_min_nxt        = r_min;
    w_sec_nxt        = r_sec;
    w_presc_nxt      = r_presc;
    w_view_valid_nxt = r_view_valid;
    w_view_idx_nxt   = r_view_idx;
    if (bus.clear_pulse) begin
      w_state_nxt      = ST_IDLE;
      w_presc_nxt      = '0;
      w_view_valid_nxt = 1'b0;
      w_view_idx_nxt   = '0;
      if (bus.count_down) begin
        w_min_nxt = (bus.preset_min > MAX_MIN_V) ? MAX_MIN_V : bus.preset_min;
        w_sec_nxt = clamp_sec(bus.preset_sec);
      end else begin
        w_min_nxt = '0;
        w_sec_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A down-count from 00:00 has nothing to count.
          if (bus.start_pulse && !(bus.count_down && (r_min == '0) && (r_sec == '0))) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            w_presc_nxt = '0;
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
          // Expiry on the same tick outranks a pause request.
          if (w_tick && w_tick_expire) begin
            w_state_nxt = ST_EXPIRED;
          end else if (bus.start_pulse) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_state_nxt = ST_RUN;
          end
          if (!w_tick || (!bus.count_down && w_at_max)) begin
            w_min_nxt = r_min;
          end else if (bus.count_down) begin
            if (r_min == '0 && r_sec == '0) begin
              w_sec_nxt = r_sec;
            end else if (r_sec == 6'd0) begin
              w_sec_nxt = SEC_MAX;
              w_min_nxt = r_min - MIN_W'(1);
            end else begin
              w_sec_nxt = r_sec - 6'd1;
            end
          end else if (r_sec == SEC_MAX) begin
            w_sec_nxt = 6'd0;
            w_min_nxt = r_min + MIN_W'(1);
          end else begin
            w_sec_nxt = r_sec + 6'd1;
          end
        end
        ST_PAUSE: begin
          if (bus.start_pulse) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          w_state_nxt = ST_EXPIRED;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
      // Recall walks 0..lap_cnt-1 then returns to the live view.
      if (bus.recall_pulse && (w_lap_cnt != '0)) begin
        if (!r_view_valid) begin
          w_view_valid_nxt = 1'b1;
          w_view_idx_nxt   = '0;
        end else if (((LAP_AW + 1)'(r_view_idx) + (LAP_AW + 1)'(1)) < w_lap_cnt) begin
          w_view_idx_nxt = r_view_idx + LAP_AW'(1);
        end else begin
          w_view_valid_nxt = 1'b0;
          w_view_idx_nxt   = '0;
        end
      end else begin
        w_view_valid_nxt = r_view_valid;
      end
    end
  end

  // State, time, prescaler and view registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= ST_IDLE;
      r_min        <= '0;
      r_sec        <= '0;
      r_presc      <= '0;
      r_view_valid <= 1'b0;
      r_view_idx   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_presc      <= w_presc_nxt;
      r_view_valid <= w_view_valid_nxt;
      r_view_idx   <= w_view_idx_nxt;
    end
  end

  assign bus.min_binary = r_view_valid ? w_rd_entry[ENTRY_W-1:SEC_W] : r_min;
  assign bus.sec_binary = r_view_valid ? w_rd_entry[SEC_W-1:0]       : r_sec;
  assign bus.running    = (r_state == ST_RUN);
  assign bus.expired    = (r_state == ST_EXPIRED);
  assign bus.lap_cnt    = w_lap_cnt;
  assign bus.lap_full   = w_lap_full;
  assign bus.view_valid = r_view_valid;
  assign bus.view_idx   = r_view_idx;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Testbench for stopwatch_lap_core: directed vector table, hand-written
// multi-cycle sequences, and randomized pulses against a seconds-based model.
module tb_stopwatch_lap_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  stopwatch_lap_core_if #(.MIN_W(7), .LAP_AW(2)) bus0 ();
  stopwatch_lap_core_if #(.MIN_W(7), .LAP_AW(2)) bus1 ();

  stopwatch_lap_core #(.CLK_HZ(4), .MIN_W(7), .MAX_MIN(99), .LAP_DEPTH(4), .LAP_AW(2))
    u_dut (.clk(clk), .rst_n(rst), .bus(bus0));

  stopwatch_lap_core #(.CLK_HZ(4), .MIN_W(7), .MAX_MIN(1), .LAP_DEPTH(4), .LAP_AW(2))
    u_dut1 (.clk(clk), .rst_n(rst), .bus(bus1));

  typedef struct {
    string      name;
    logic       clr, st, lp, cd;
    logic [6:0] pm;
    logic [5:0] ps;
    int         idle;
    logic [6:0] emin;
    logic [5:0] esec;
    logic       erun, eexp;
    logic [2:0] elap;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle pulse on bus0, starting and ending at a negedge.
  task automatic pulse(input logic clr, input logic st, input logic lp, input logic rc);
    bus0.clear_pulse = clr; bus0.start_pulse = st; bus0.lap_pulse = lp; bus0.recall_pulse = rc;
    @(negedge clk);
    bus0.clear_pulse = 1'b0; bus0.start_pulse = 1'b0; bus0.lap_pulse = 1'b0; bus0.recall_pulse = 1'b0;
  endtask

  // Reference model: time kept as total seconds, laps in a queue.
  localparam int CLK_HZ = 4;
  localparam int TOP_S  = 99 * 60 + 59;
  int m_mode;   // 0 idle, 1 run, 2 pause, 3 expired
  int m_total, m_phase, m_view;
  int m_laps[$];

  function automatic void model_step(input bit clr, input bit st, input bit lp, input bit rc,
                                     input bit cd, input int pm, input int ps);
    int  n_laps;
    int  old_total;
    int  old_mode;
    bit  tick;
    if (clr) begin
      m_mode  = 0;
      m_total = cd ? ((pm > 99 ? 99 : pm) * 60 + (ps > 59 ? 59 : ps)) : 0;
      m_phase = 0;
      m_laps.delete();
      m_view  = -1;
      return;
    end
    n_laps    = m_laps.size();
    old_total = m_total;
    old_mode  = m_mode;
    tick      = (old_mode == 1) && (m_phase == CLK_HZ - 1);
    if (old_mode == 1) m_phase = tick ? 0 : m_phase + 1;
    if (lp && old_mode == 1 && n_laps < 4) m_laps.push_back(old_total);
    if (rc && n_laps > 0) begin
      if (m_view < 0) m_view = 0;
      else if (m_view < n_laps - 1) m_view = m_view + 1;
      else m_view = -1;
    end
    if (st) begin
      if (old_mode == 0 && !(cd && old_total == 0)) m_mode = 1;
      else if (old_mode == 1) m_mode = 2;
      else if (old_mode == 2) m_mode = 1;
    end
    if (tick) begin
      if (cd) begin
        if (old_total <= 1) begin m_total = 0; m_mode = 3; end
        else m_total = old_total - 1;
      end else begin
        if (old_total == TOP_S) m_mode = 3;
        else m_total = old_total + 1;
      end
    end
  endfunction

  function automatic logic [31:0] model_out();
    int shown;
    shown = (m_view >= 0) ? m_laps[m_view] : m_total;
    return {10'd0, 7'(shown / 60), 6'(shown % 60), (m_mode == 1), (m_mode == 3),
            3'(m_laps.size()), (m_laps.size() == 4), (m_view >= 0), 2'(m_view < 0 ? 0 : m_view)};
  endfunction

  function automatic logic [31:0] dut_out();
    return {10'd0, bus0.min_binary, bus0.sec_binary, bus0.running, bus0.expired,
            bus0.lap_cnt, bus0.lap_full, bus0.view_valid, bus0.view_idx};
  endfunction

  initial begin
    bit clr, st, lp, rc, cd;
    int pm, ps;
    // name, clr, st, lp, cd, pm, ps, idle, emin, esec, erun, eexp, elap
    vecs[0]  = '{"clear_up",      1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  0,   7'd0,  6'd0,  1'b0, 1'b0, 3'd0};
    vecs[1]  = '{"up_240",        1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  240, 7'd1,  6'd0,  1'b1, 1'b0, 3'd0};
    vecs[2]  = '{"pause_hold",    1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  20,  7'd1,  6'd0,  1'b0, 1'b0, 3'd0};
    vecs[3]  = '{"resume_phase",  1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  3,   7'd1,  6'd1,  1'b1, 1'b0, 3'd0};
    vecs[4]  = '{"down_preset",   1'b1, 1'b0, 1'b0, 1'b1, 7'd0,   6'd2,  0,   7'd0,  6'd2,  1'b0, 1'b0, 3'd0};
    vecs[5]  = '{"down_expire",   1'b0, 1'b1, 1'b0, 1'b1, 7'd0,   6'd2,  8,   7'd0,  6'd0,  1'b0, 1'b1, 3'd0};
    vecs[6]  = '{"expired_start", 1'b0, 1'b1, 1'b0, 1'b1, 7'd0,   6'd2,  4,   7'd0,  6'd0,  1'b0, 1'b1, 3'd0};
    vecs[7]  = '{"zero_preset",   1'b1, 1'b0, 1'b0, 1'b1, 7'd0,   6'd0,  0,   7'd0,  6'd0,  1'b0, 1'b0, 3'd0};
    vecs[8]  = '{"zero_start",    1'b0, 1'b1, 1'b0, 1'b1, 7'd0,   6'd0,  2,   7'd0,  6'd0,  1'b0, 1'b0, 3'd0};
    vecs[9]  = '{"clamp_sec",     1'b1, 1'b0, 1'b0, 1'b1, 7'd7,   6'd63, 0,   7'd7,  6'd59, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{"clamp_min",     1'b1, 1'b0, 1'b0, 1'b1, 7'd120, 6'd10, 0,   7'd99, 6'd10, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{"down_tick",     1'b0, 1'b1, 1'b0, 1'b1, 7'd120, 6'd10, 4,   7'd99, 6'd9,  1'b1, 1'b0, 3'd0};
    vecs[12] = '{"lap_and_pause", 1'b0, 1'b1, 1'b1, 1'b1, 7'd120, 6'd10, 0,   7'd99, 6'd9,  1'b0, 1'b0, 3'd1};
    vecs[13] = '{"resume_down",   1'b0, 1'b1, 1'b0, 1'b1, 7'd120, 6'd10, 3,   7'd99, 6'd8,  1'b1, 1'b0, 3'd1};
    vecs[14] = '{"clear_laps",    1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  0,   7'd0,  6'd0,  1'b0, 1'b0, 3'd0};

    bus0.start_pulse = 1'b0; bus0.lap_pulse = 1'b0; bus0.clear_pulse = 1'b0; bus0.recall_pulse = 1'b0;
    bus0.count_down = 1'b0; bus0.preset_min = 7'd0; bus0.preset_sec = 6'd0;
    bus1.start_pulse = 1'b0; bus1.lap_pulse = 1'b0; bus1.clear_pulse = 1'b0; bus1.recall_pulse = 1'b0;
    bus1.count_down = 1'b0; bus1.preset_min = 7'd0; bus1.preset_sec = 6'd0;

    @(negedge clk);
    @(negedge clk);
    check("reset_state", dut_out(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      bus0.count_down = vecs[i].cd; bus0.preset_min = vecs[i].pm; bus0.preset_sec = vecs[i].ps;
      pulse(vecs[i].clr, vecs[i].st, vecs[i].lp, 1'b0);
      repeat (vecs[i].idle) @(negedge clk);
      check(vecs[i].name,
            {14'd0, bus0.min_binary, bus0.sec_binary, bus0.running, bus0.expired, bus0.lap_cnt},
            {14'd0, vecs[i].emin, vecs[i].esec, vecs[i].erun, vecs[i].eexp, vecs[i].elap});
    end

    // Lap capture until full, then recall walk while the live counter continues.
    bus0.count_down = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("lap_time_%0d", k), {19'd0, bus0.min_binary, bus0.sec_binary}, {19'd0, 7'd0, 6'(k)});
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
    end
    check("lap_full", {28'd0, bus0.lap_cnt, bus0.lap_full}, {28'd0, 3'd4, 1'b1});
    for (int r = 0; r < 4; r++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("recall_%0d", r), {16'd0, bus0.view_valid, bus0.view_idx, bus0.min_binary, bus0.sec_binary},
            {16'd0, 1'b1, 2'(r), 7'd0, 6'(r + 1)});
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("recall_live", {17'd0, bus0.view_valid, bus0.running, bus0.min_binary, bus0.sec_binary},
          {17'd0, 1'b0, 1'b1, 7'd0, 6'd7});

    // Clear coincident with start+lap while running.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("pre_clear_time", {19'd0, bus0.min_binary, bus0.sec_binary}, {19'd0, 7'd0, 6'd3});
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("clear_priority", dut_out(), 32'd0);

    // MAX_MIN=1 instance: expiry at 01:59 and hold.
    bus1.clear_pulse = 1'b1; @(negedge clk); bus1.clear_pulse = 1'b0;
    bus1.start_pulse = 1'b1; @(negedge clk); bus1.start_pulse = 1'b0;
    repeat (480) @(negedge clk);
    check("max_expire", {17'd0, bus1.min_binary, bus1.sec_binary, bus1.running, bus1.expired},
          {17'd0, 7'd1, 6'd59, 1'b0, 1'b1});
    repeat (40) @(negedge clk);
    check("max_hold", {17'd0, bus1.min_binary, bus1.sec_binary, bus1.running, bus1.expired},
          {17'd0, 7'd1, 6'd59, 1'b0, 1'b1});

    // Asynchronous reset mid-run with a lap stored and being viewed.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_view", {22'd0, bus0.view_valid, bus0.lap_cnt, bus0.running, bus0.sec_binary},
          {22'd0, 1'b1, 3'd1, 1'b1, 6'd1});
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", dut_out(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized pulses against the model.
    cd = 1'b0; pm = 0; ps = 0;
    for (int i = 0; i < 1500; i++) begin
      clr = (i == 0) || ($urandom_range(0, 199) == 0);
      if (clr) begin
        cd = 1'($urandom_range(0, 1));
        pm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
        ps = int'($urandom_range(0, 63));
      end
      st = ($urandom_range(0, 19) == 0);
      lp = ($urandom_range(0, 7) == 0);
      rc = ($urandom_range(0, 5) == 0);
      bus0.count_down = cd; bus0.preset_min = 7'(pm); bus0.preset_sec = 6'(ps);
      bus0.clear_pulse = clr; bus0.start_pulse = st; bus0.lap_pulse = lp; bus0.recall_pulse = rc;
      model_step(clr, st, lp, rc, cd, pm, ps);
      @(negedge clk);
      check($sformatf("rand_%0d", i), dut_out(), model_out());
    end
    bus0.clear_pulse = 1'b0; bus0.start_pulse = 1'b0; bus0.lap_pulse = 1'b0; bus0.recall_pulse = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
